// File: rtl/clock_ctrl_pkg.sv
// Shared types and defaults for the time-of-day key controller.
// Holds the state encodings, key indices, default timings and counter helpers.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_MIN  = 2'd1,
        ST_SET_HOUR = 2'd2
    } state_e;

    localparam int KEY_SET  = 0;
    localparam int KEY_UP   = 1;
    localparam int KEY_VIEW = 2;
    localparam int KEY_FMT  = 3;
    localparam int NUM_KEYS = 4;

    localparam int DEB_CYCLES_DEF    = 20;
    localparam int REPEAT_DELAY_DEF  = 500;
    localparam int REPEAT_PERIOD_DEF = 100;
    localparam int TIMEOUT_DEF       = 5000;
    localparam int BLINK_HALF_DEF    = 250;

    // Bits needed by a down-counter that is loaded with n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic state_e next_set_state(input state_e s);
        case (s)
            ST_RUN:     return ST_SET_MIN;
            ST_SET_MIN: return ST_SET_HOUR;
            default:    return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_ctrl_key_debounce.sv
// One key lane: two-flop synchronizer, debounce down-counter and press-event register.
// The level flips only after DEB_CYCLES consecutive disagreeing samples.
module key_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic clr_ni,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    localparam int            DW       = cnt_width(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          lvl_dly_q;
    logic          press_q;

    always_comb begin
        cnt_d = DEB_LOAD;
        lvl_d = lvl_q;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == '0) begin
                lvl_d = ~lvl_q;
            end else begin
                cnt_d = cnt_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            sync_q    <= '0;
            cnt_q     <= DEB_LOAD;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            press_q   <= lvl_q & ~lvl_dly_q;
        end
    end

    assign level_o = lvl_q;
    assign press_o = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// Key-driven sequencer for the BCD time-of-day core: RUN / SET_MIN / SET_HOUR,
// manual increment pulses with auto-repeat, inactivity timeout and field blink.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF,
    parameter int BLINK_HALF    = BLINK_HALF_DEF
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       key_set,
    input  logic       key_up,
    input  logic       key_view,
    input  logic       key_fmt,
    output logic       enable,
    output logic       mode,
    output logic       madd,
    output logic       madd_sig,
    output logic       hadd,
    output logic       hadd_sig,
    output logic       hourMode,
    output logic       blink,
    output logic [1:0] state
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = cnt_width(RPT_MAX);
    localparam int TW      = cnt_width(TIMEOUT);
    localparam int BW      = cnt_width(BLINK_HALF);

    localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BL_LOAD = BW'(BLINK_HALF - 1);

    logic [NUM_KEYS-1:0] key_raw, key_lvl, key_prs;
    logic                p_set, p_up, p_view, p_fmt, any_press, up_lvl;
    logic                unused_lvl;

    assign key_raw = {key_fmt, key_view, key_up, key_set};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i   (clk),
            .clr_ni  (clr_n),
            .key_i   (key_raw[k]),
            .level_o (key_lvl[k]),
            .press_o (key_prs[k])
        );
    end

    assign p_set      = key_prs[KEY_SET];
    assign p_up       = key_prs[KEY_UP];
    assign p_view     = key_prs[KEY_VIEW];
    assign p_fmt      = key_prs[KEY_FMT];
    assign any_press  = |key_prs;
    assign up_lvl     = key_lvl[KEY_UP];
    assign unused_lvl = key_lvl[KEY_SET] ^ key_lvl[KEY_VIEW] ^ key_lvl[KEY_FMT];

    state_e        state_q, state_d, pend_tgt_q, pend_tgt_d, tr_tgt;
    logic          pend_vld_q, pend_vld_d, state_chg_q, tr_req;
    logic          in_set, pulse_hi, to_hit, rpt_tick, up_req;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_act_q, rpt_act_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          enable_q, enable_d, mode_q, mode_d, mode_save_q, mode_save_d;
    logic          madd_q, madd_d, hadd_q, hadd_d;
    logic          madd_sig_q, madd_sig_d, hadd_sig_q, hadd_sig_d;
    logic          hour_q, hour_d, blink_q, blink_d;

    assign in_set   = (state_q != ST_RUN);
    assign pulse_hi = madd_q | hadd_q;
    assign to_hit   = (to_cnt_q == '0);
    assign rpt_tick = rpt_act_q && (rpt_cnt_q == '0) && up_lvl;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_RUN;
            pend_vld_q  <= 1'b0;
            pend_tgt_q  <= ST_RUN;
            state_chg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_tgt_q  <= pend_tgt_d;
            state_chg_q <= (state_d != state_q);
        end
    end

    // A transition requested while an increment pulse is high waits one cycle,
    // so the pulse never sits next to a select change.
    always_comb begin
        state_d    = state_q;
        pend_vld_d = 1'b0;
        pend_tgt_d = pend_tgt_q;
        tr_req     = 1'b0;
        tr_tgt     = state_q;
        if (pend_vld_q) begin
            tr_req = 1'b1;
            tr_tgt = pend_tgt_q;
        end else if (p_set) begin
            tr_req = 1'b1;
            tr_tgt = next_set_state(state_q);
        end else if (in_set && to_hit) begin
            tr_req = 1'b1;
            tr_tgt = ST_RUN;
        end
        if (tr_req) begin
            if (pulse_hi) begin
                pend_vld_d = 1'b1;
                pend_tgt_d = tr_tgt;
            end else begin
                state_d = tr_tgt;
            end
        end
    end

    assign up_req = in_set && (p_up || rpt_tick) && !tr_req && !pulse_hi && !state_chg_q;

    always_comb begin
        enable_d    = (state_d == ST_RUN);
        madd_sig_d  = (state_d == ST_SET_MIN);
        hadd_sig_d  = (state_d == ST_SET_HOUR);
        madd_d      = up_req && (state_q == ST_SET_MIN);
        hadd_d      = up_req && (state_q == ST_SET_HOUR);
        hour_d      = hour_q ^ p_fmt;
        mode_d      = mode_q;
        mode_save_d = mode_save_q;
        if (state_d != ST_RUN) begin
            mode_d = 1'b1;
            if (!in_set) begin
                mode_save_d = mode_q ^ p_view;
            end
        end else if (in_set) begin
            mode_d = mode_save_q;
        end else if (p_view) begin
            mode_d = ~mode_q;
        end
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (state_q == ST_RUN || state_d == ST_RUN) begin
            blink_d     = 1'b0;
            blink_cnt_d = BL_LOAD;
        end else if (blink_cnt_q == '0) begin
            blink_d     = ~blink_q;
            blink_cnt_d = BL_LOAD;
        end else begin
            blink_cnt_d = blink_cnt_q - BW'(1);
        end
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!in_set || any_press) begin
            to_cnt_d = TO_LOAD;
        end else if (!to_hit) begin
            to_cnt_d = to_cnt_q - TW'(1);
        end
        rpt_act_d = rpt_act_q;
        rpt_cnt_d = rpt_cnt_q;
        if (!in_set || !up_lvl || (state_d != state_q)) begin
            rpt_act_d = 1'b0;
        end else if (up_req && p_up) begin
            rpt_act_d = 1'b1;
            rpt_cnt_d = RD_LOAD;
        end else if (rpt_tick) begin
            rpt_cnt_d = RP_LOAD;
        end else if (rpt_act_q && (rpt_cnt_q != '0)) begin
            rpt_cnt_d = rpt_cnt_q - RW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            to_cnt_q    <= TO_LOAD;
            rpt_cnt_q   <= RD_LOAD;
            rpt_act_q   <= 1'b0;
            blink_cnt_q <= BL_LOAD;
            blink_q     <= 1'b0;
            enable_q    <= 1'b1;
            mode_q      <= 1'b1;
            mode_save_q <= 1'b1;
            madd_q      <= 1'b0;
            hadd_q      <= 1'b0;
            madd_sig_q  <= 1'b0;
            hadd_sig_q  <= 1'b0;
            hour_q      <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_act_q   <= rpt_act_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            mode_save_q <= mode_save_d;
            madd_q      <= madd_d;
            hadd_q      <= hadd_d;
            madd_sig_q  <= madd_sig_d;
            hadd_sig_q  <= hadd_sig_d;
            hour_q      <= hour_d;
        end
    end

    assign enable   = enable_q;
    assign mode     = mode_q;
    assign madd     = madd_q;
    assign hadd     = hadd_q;
    assign madd_sig = madd_sig_q;
    assign hadd_sig = hadd_sig_q;
    assign hourMode = hour_q;
    assign blink    = blink_q;
    assign state    = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with short timings; increment pulses are
// checked against a queue of expected cycle numbers filled when keys are driven.
module tb_clock_ctrl;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       key_set = 1'b0, key_up = 1'b0, key_view = 1'b0, key_fmt = 1'b0;
    logic       enable, mode, madd, madd_sig, hadd, hadd_sig, hourMode, blink;
    logic [1:0] state;

    clock_ctrl #(
        .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .TIMEOUT(100), .BLINK_HALF(8)
    ) dut (
        .clk(clk), .clr_n(clr_n),
        .key_set(key_set), .key_up(key_up), .key_view(key_view), .key_fmt(key_fmt),
        .enable(enable), .mode(mode), .madd(madd), .madd_sig(madd_sig),
        .hadd(hadd), .hadd_sig(hadd_sig), .hourMode(hourMode), .blink(blink), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    int   exp_madd[$];
    int   exp_hadd[$];
    logic madd_prev = 1'b0, hadd_prev = 1'b0;

    // A raw key driven at a negedge with cycle count D gives its press event at D+7
    // and its increment pulse at D+8.
    always @(negedge clk) begin
        if (!clr_n) begin
            madd_prev = 1'b0;
            hadd_prev = 1'b0;
        end else begin
            if (madd) begin
                int e;
                e = (exp_madd.size() > 0) ? exp_madd.pop_front() : -1;
                chk("madd_width", madd_prev, 0);
                chk("madd_cycle", cyc, e);
            end
            if (hadd) begin
                int e;
                e = (exp_hadd.size() > 0) ? exp_hadd.pop_front() : -1;
                chk("hadd_width", hadd_prev, 0);
                chk("hadd_cycle", cyc, e);
            end
            madd_prev = madd;
            hadd_prev = hadd;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, b, u, r, d7, u7, h;

        #2 clr_n = 1'b0;
        wait_cyc(3);
        chk("rst_state", state, 0);
        chk("rst_enable", enable, 1);
        chk("rst_mode", mode, 1);
        chk("rst_others", {madd, madd_sig, hadd, hadd_sig, hourMode, blink}, 0);
        clr_n = 1'b1;

        // RUN: view toggles mode, fmt toggles hourMode, up is ignored
        d = 5;
        wait_cyc(d); key_view = 1'b1;
        wait_cyc(d + 7); chk("view_mode_pre", mode, 1);
        wait_cyc(d + 8); chk("view_mode", mode, 0);
        wait_cyc(d + 10); key_view = 1'b0;
        d = d + 20;
        wait_cyc(d); key_fmt = 1'b1;
        wait_cyc(d + 8); chk("fmt_hour", hourMode, 1);
        wait_cyc(d + 10); key_fmt = 1'b0;
        d = d + 20;
        wait_cyc(d); key_up = 1'b1;
        wait_cyc(d + 12); key_up = 1'b0;
        chk("run_up_state", state, 0);

        // Bouncing key_set, then stable high
        b = d + 30;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(b + i);
            key_set = ((i / 2) % 2 == 0);
        end
        d = b + 20;
        wait_cyc(d); key_set = 1'b1;
        chk("bounce_state", state, 0);
        wait_cyc(d + 7); chk("bounce_pre", state, 0);
        wait_cyc(d + 8);
        chk("bounce_state_min", state, 1);
        chk("bounce_madd_sig", madd_sig, 1);
        chk("bounce_enable", enable, 0);
        chk("setmin_mode", mode, 1);
        wait_cyc(d + 9); key_set = 1'b0;
        wait_cyc(d + 15); chk("blink_pre", blink, 0);
        wait_cyc(d + 16); chk("blink_on", blink, 1);
        wait_cyc(d + 24); chk("blink_off", blink, 0);

        // Single press plus auto-repeat
        u = d + 30;
        wait_cyc(u); key_up = 1'b1;
        exp_madd.push_back(u + 8);
        exp_madd.push_back(u + 28);
        exp_madd.push_back(u + 33);
        exp_madd.push_back(u + 38);
        exp_madd.push_back(u + 43);
        wait_cyc(u + 39); key_up = 1'b0;
        chk("rpt_state", state, 1);

        // key_set and key_up press events in the same cycle
        r = u + 60;
        wait_cyc(r); key_set = 1'b1; key_up = 1'b1;
        wait_cyc(r + 8);
        chk("simul_state", state, 2);
        chk("simul_hadd_sig", hadd_sig, 1);
        chk("simul_madd_sig", madd_sig, 0);
        wait_cyc(r + 10); key_set = 1'b0; key_up = 1'b0;

        // Inactivity timeout from SET_HOUR
        wait_cyc(r + 107); chk("to_pre_state", state, 2);
        wait_cyc(r + 108);
        chk("to_state", state, 0);
        chk("to_hadd_sig", hadd_sig, 0);
        chk("to_enable", enable, 1);
        chk("to_blink", blink, 0);
        chk("to_mode_restore", mode, 0);
        chk("to_hour", hourMode, 1);

        // key_set press lands while madd is high
        d7 = r + 115;
        wait_cyc(d7); key_set = 1'b1;
        wait_cyc(d7 + 8); chk("dfr_enter", state, 1);
        wait_cyc(d7 + 10); key_set = 1'b0;
        u7 = d7 + 30;
        wait_cyc(u7); key_up = 1'b1;
        exp_madd.push_back(u7 + 8);
        wait_cyc(u7 + 1); key_set = 1'b1;
        wait_cyc(u7 + 9);
        chk("dfr_hold_state", state, 1);
        chk("dfr_madd_before", madd, 0);
        wait_cyc(u7 + 10);
        chk("dfr_state", state, 2);
        chk("dfr_madd_at_chg", madd, 0);
        chk("dfr_hadd_sig", hadd_sig, 1);
        chk("dfr_madd_sig", madd_sig, 0);
        wait_cyc(u7 + 12); key_up = 1'b0; key_set = 1'b0;

        // Hour increment in SET_HOUR
        h = u7 + 30;
        wait_cyc(h); key_up = 1'b1;
        exp_hadd.push_back(h + 8);
        wait_cyc(h + 12); key_up = 1'b0;

        // Asynchronous reset mid-sequence
        wait_cyc(h + 20);
        chk("pre_rst_sig", hadd_sig, 1);
        #2 clr_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_enable", enable, 1);
        chk("mid_rst_mode", mode, 1);
        chk("mid_rst_others", {madd, madd_sig, hadd, hadd_sig, hourMode, blink}, 0);
        @(negedge clk);
        clr_n = 1'b1;
        wait_cyc(cyc + 10);
        chk("post_rst_state", state, 0);

        chk("madd_left", exp_madd.size(), 0);
        chk("hadd_left", exp_hadd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
